ni_requester: RTL and testbench

NI_REQUESTER -- requirements
Module: ni_requester

---
 rtl/pa_noc.sv | 30 +++
 rtl/ni_pkt_codec.sv | 54 +++++
 rtl/ni_requester.sv | 171 +++++++++++++++++
 tb/tb_ni_requester.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_noc.sv
// Shared NoC definitions: the 60-bit packet layout, packet kinds and the requester FSM states.
package pa_noc;

    localparam int APB_PACKET_WIDTH = 60;
    localparam int COORD_BITS       = 2;

    localparam int DST_COL_LSB = 0;
    localparam int DST_ROW_LSB = 2;
    localparam int SRC_COL_LSB = 4;
    localparam int SRC_ROW_LSB = 6;
    localparam int VALID_BIT   = 8;
    localparam int KIND_BIT    = 9;
    localparam int WRITE_BIT   = 10;
    localparam int ERR_BIT     = 11;
    localparam int ADDR_LSB    = 12;
    localparam int ADDR_BITS   = 16;
    localparam int DATA_LSB    = 28;
    localparam int DATA_BITS   = 32;

    localparam logic KIND_REQ = 1'b0;
    localparam logic KIND_RSP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } niState_e;

endpackage

// File: rtl/ni_pkt_codec.sv
// Purely combinational pack (tx side) and unpack (rx side) of NoC packet fields.
module ni_pkt_codec
    import pa_noc::*;
(
    input  logic [COORD_BITS-1:0]       i_txDstRow,
    input  logic [COORD_BITS-1:0]       i_txDstCol,
    input  logic [COORD_BITS-1:0]       i_txSrcRow,
    input  logic [COORD_BITS-1:0]       i_txSrcCol,
    input  logic                        i_txValid,
    input  logic                        i_txKind,
    input  logic                        i_txWrite,
    input  logic                        i_txErr,
    input  logic [ADDR_BITS-1:0]        i_txAddr,
    input  logic [DATA_BITS-1:0]        i_txData,
    output logic [APB_PACKET_WIDTH-1:0] o_txPacket,
    input  logic [APB_PACKET_WIDTH-1:0] i_rxPacket,
    output logic [COORD_BITS-1:0]       o_rxDstRow,
    output logic [COORD_BITS-1:0]       o_rxDstCol,
    output logic [COORD_BITS-1:0]       o_rxSrcRow,
    output logic [COORD_BITS-1:0]       o_rxSrcCol,
    output logic                        o_rxValid,
    output logic                        o_rxKind,
    output logic                        o_rxWrite,
    output logic                        o_rxErr,
    output logic [ADDR_BITS-1:0]        o_rxAddr,
    output logic [DATA_BITS-1:0]        o_rxData
);

    always_comb begin
        o_txPacket                              = '0;
        o_txPacket[DST_COL_LSB +: COORD_BITS]   = i_txDstCol;
        o_txPacket[DST_ROW_LSB +: COORD_BITS]   = i_txDstRow;
        o_txPacket[SRC_COL_LSB +: COORD_BITS]   = i_txSrcCol;
        o_txPacket[SRC_ROW_LSB +: COORD_BITS]   = i_txSrcRow;
        o_txPacket[VALID_BIT]                   = i_txValid;
        o_txPacket[KIND_BIT]                    = i_txKind;
        o_txPacket[WRITE_BIT]                   = i_txWrite;
        o_txPacket[ERR_BIT]                     = i_txErr;
        o_txPacket[ADDR_LSB +: ADDR_BITS]       = i_txAddr;
        o_txPacket[DATA_LSB +: DATA_BITS]       = i_txData;
    end

    assign o_rxDstCol = i_rxPacket[DST_COL_LSB +: COORD_BITS];
    assign o_rxDstRow = i_rxPacket[DST_ROW_LSB +: COORD_BITS];
    assign o_rxSrcCol = i_rxPacket[SRC_COL_LSB +: COORD_BITS];
    assign o_rxSrcRow = i_rxPacket[SRC_ROW_LSB +: COORD_BITS];
    assign o_rxValid  = i_rxPacket[VALID_BIT];
    assign o_rxKind   = i_rxPacket[KIND_BIT];
    assign o_rxWrite  = i_rxPacket[WRITE_BIT];
    assign o_rxErr    = i_rxPacket[ERR_BIT];
    assign o_rxAddr   = i_rxPacket[ADDR_LSB +: ADDR_BITS];
    assign o_rxData   = i_rxPacket[DATA_LSB +: DATA_BITS];

endmodule

// File: rtl/ni_requester.sv
// APB completer that turns each access into a NoC request packet and waits,
// with a timeout, for the matching response before completing the APB transfer.
module ni_requester
    import pa_noc::*;
#(
    parameter int GRID_WIDTH     = 4,
    parameter int NODE_ROW       = 0,
    parameter int NODE_COL       = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [15:0]                 i_paddr,
    input  logic [31:0]                 i_pwdata,
    output logic                        o_pready,
    output logic [31:0]                 o_prdata,
    output logic                        o_pslverr,
    output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
    input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket,
    output logic                        o_timeout,
    output logic                        o_dropped
);

    localparam int COORD_WIDTH = $clog2(GRID_WIDTH);
    localparam int CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [COORD_WIDTH-1:0] OWN_ROW   = COORD_WIDTH'(NODE_ROW);
    localparam logic [COORD_WIDTH-1:0] OWN_COL   = COORD_WIDTH'(NODE_COL);
    localparam logic [CNT_WIDTH-1:0]   WAIT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    niState_e                    state_q;
    logic [COORD_WIDTH-1:0]      dstRow_q;
    logic [COORD_WIDTH-1:0]      dstCol_q;
    logic                        write_q;
    logic                        err_q;
    logic [31:0]                 rdata_q;
    logic [CNT_WIDTH-1:0]        waitCnt_q;
    logic [APB_PACKET_WIDTH-1:0] packet_q;
    logic                        timeout_q;
    logic                        dropped_q;

    logic [COORD_WIDTH-1:0]      reqDstRow;
    logic [COORD_WIDTH-1:0]      reqDstCol;
    logic                        reqIsSelf;
    logic [APB_PACKET_WIDTH-1:0] reqPacket;

    logic [COORD_WIDTH-1:0]      rxDstRow;
    logic [COORD_WIDTH-1:0]      rxDstCol;
    logic [COORD_WIDTH-1:0]      rxSrcRow;
    logic [COORD_WIDTH-1:0]      rxSrcCol;
    logic                        rxValid;
    logic                        rxKind;
    logic                        rxWrite;
    logic                        rxErr;
    logic [15:0]                 rxAddr;
    logic [31:0]                 rxData;
    logic [16:0]                 unusedRx;

    logic                        rspMatch;
    logic                        doneAccess;

    assign reqDstRow = i_paddr[15:14];
    assign reqDstCol = i_paddr[13:12];
    assign reqIsSelf = (reqDstRow == OWN_ROW) && (reqDstCol == OWN_COL);

    ni_pkt_codec u_codec (
        .i_txDstRow (reqDstRow),
        .i_txDstCol (reqDstCol),
        .i_txSrcRow (OWN_ROW),
        .i_txSrcCol (OWN_COL),
        .i_txValid  (1'b1),
        .i_txKind   (KIND_REQ),
        .i_txWrite  (i_pwrite),
        .i_txErr    (1'b0),
        .i_txAddr   (i_paddr),
        .i_txData   (i_pwdata),
        .o_txPacket (reqPacket),
        .i_rxPacket (i_apbPacket),
        .o_rxDstRow (rxDstRow),
        .o_rxDstCol (rxDstCol),
        .o_rxSrcRow (rxSrcRow),
        .o_rxSrcCol (rxSrcCol),
        .o_rxValid  (rxValid),
        .o_rxKind   (rxKind),
        .o_rxWrite  (rxWrite),
        .o_rxErr    (rxErr),
        .o_rxAddr   (rxAddr),
        .o_rxData   (rxData)
    );

    assign unusedRx = {rxAddr, rxWrite};

    // Only a response from the node we asked, addressed to us, while waiting, counts.
    assign rspMatch = (state_q == ST_WAIT) && rxValid && (rxKind == KIND_RSP)
                   && (rxDstRow == OWN_ROW) && (rxDstCol == OWN_COL)
                   && (rxSrcRow == dstRow_q) && (rxSrcCol == dstCol_q);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_IDLE;
            dstRow_q  <= '0;
            dstCol_q  <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            waitCnt_q <= '0;
            packet_q  <= '0;
            timeout_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            packet_q  <= '0;
            timeout_q <= 1'b0;
            dropped_q <= rxValid && !rspMatch;
            case (state_q)
                ST_IDLE: begin
                    if (i_psel && !i_penable) begin
                        dstRow_q <= reqDstRow;
                        dstCol_q <= reqDstCol;
                        write_q  <= i_pwrite;
                        rdata_q  <= '0;
                        // A node cannot address itself through the mesh; fail immediately.
                        if (reqIsSelf) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q    <= 1'b0;
                            packet_q <= reqPacket;
                            state_q  <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    waitCnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rspMatch) begin
                        rdata_q <= rxData;
                        err_q   <= rxErr;
                        state_q <= ST_DONE;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_psel && i_penable) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign doneAccess  = (state_q == ST_DONE) && i_psel && i_penable;
    assign o_pready    = doneAccess;
    assign o_pslverr   = doneAccess && err_q;
    assign o_prdata    = (doneAccess && !write_q) ? rdata_q : '0;
    assign o_apbPacket = packet_q;
    assign o_timeout   = timeout_q;
    assign o_dropped   = dropped_q;

endmodule

// File: tb/tb_ni_requester.sv
// Randomized self-checking bench for ni_requester at node (1,1) with an 8-cycle response timeout.
module tb_ni_requester;

    localparam int TMO    = 8;
    localparam int WINDOW = TMO + 4;

    logic        i_clk;
    logic        i_arst_n;
    logic        i_psel;
    logic        i_penable;
    logic        i_pwrite;
    logic [15:0] i_paddr;
    logic [31:0] i_pwdata;
    logic        o_pready;
    logic [31:0] o_prdata;
    logic        o_pslverr;
    logic [59:0] o_apbPacket;
    logic [59:0] i_apbPacket;
    logic        o_timeout;
    logic        o_dropped;

    int checks = 0;
    int errors = 0;

    ni_requester #(
        .GRID_WIDTH     (4),
        .NODE_ROW       (1),
        .NODE_COL       (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_psel      (i_psel),
        .i_penable   (i_penable),
        .i_pwrite    (i_pwrite),
        .i_paddr     (i_paddr),
        .i_pwdata    (i_pwdata),
        .o_pready    (o_pready),
        .o_prdata    (o_prdata),
        .o_pslverr   (o_pslverr),
        .o_apbPacket (o_apbPacket),
        .i_apbPacket (i_apbPacket),
        .o_timeout   (o_timeout),
        .o_dropped   (o_dropped)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Packet value built arithmetically from the field layout table.
    function automatic logic [59:0] mkPkt(input longint unsigned dr, input longint unsigned dc,
                                          input longint unsigned sr, input longint unsigned sc,
                                          input longint unsigned valid, input longint unsigned kind,
                                          input longint unsigned wr, input longint unsigned err,
                                          input longint unsigned addr, input longint unsigned data);
        longint unsigned v;
        v = dc + dr * 4 + sc * 16 + sr * 64 + valid * 256 + kind * 512 + wr * 1024
          + err * 2048 + addr * 4096 + data * 268435456;
        return v[59:0];
    endfunction

    task automatic runTxn(input string name, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic wr, input int rspAt, input logic [31:0] rspData,
                          input logic rspErr, input int wrongAt, input int wrongKind);
        longint unsigned dr;
        longint unsigned dc;
        bit              isSelf;
        bit              matched;
        int              expReady;
        int              expTmo;
        int              expDrop;
        logic [31:0]     expRdata;
        logic            expErr;
        logic [59:0]     expPkt;
        logic [59:0]     rspPkt;
        logic [59:0]     wrongPkt;
        int              pktCount   = 0;
        int              pktCycle   = -1;
        logic [59:0]     pktSeen    = '0;
        int              readyCount = 0;
        int              readyCycle = -1;
        logic [31:0]     rdSeen     = '0;
        logic            errSeen    = 1'b0;
        int              tmoCount   = 0;
        int              tmoCycle   = -1;
        int              dropCount  = 0;
        int              dropCycle  = -1;
        int              stray      = 0;

        dr       = longint'(addr[15:14]);
        dc       = longint'(addr[13:12]);
        isSelf   = (dr == 1) && (dc == 1);
        matched  = !isSelf && rspAt >= 1 && rspAt <= TMO;
        expPkt   = mkPkt(dr, dc, 1, 1, 1, 0, longint'(wr), 0, longint'(addr), longint'(wdata));
        rspPkt   = mkPkt(1, 1, dr, dc, 1, 1, $urandom_range(0, 1), longint'(rspErr),
                         $urandom_range(0, 65535), longint'(rspData));
        case (wrongKind)
            0:       wrongPkt = mkPkt(1, 1, (dr + 1) % 4, dc, 1, 1, 0, 0, 0, 32'h0BAD0BAD);
            1:       wrongPkt = mkPkt(2, 1, dr, dc, 1, 1, 0, 0, 0, 32'h0BAD0BAD);
            2:       wrongPkt = mkPkt(1, 1, dr, dc, 1, 0, 0, 0, 0, 32'h0BAD0BAD);
            default: wrongPkt = mkPkt(1, 1, 2, 2, 1, 1, 0, 0, 0, 32'h0BAD0BAD);
        endcase
        expReady = isSelf ? 0 : (matched ? rspAt + 1 : TMO + 1);
        expTmo   = (!isSelf && !matched) ? 1 : 0;
        expDrop  = ((wrongAt > 0) ? 1 : 0) + ((rspAt > 0 && !matched) ? 1 : 0);
        expRdata = (matched && !wr) ? rspData : 32'h0;
        expErr   = matched ? rspErr : 1'b1;

        @(posedge i_clk); #1;
        i_psel      = 1'b1;
        i_penable   = 1'b0;
        i_paddr     = addr;
        i_pwdata    = wdata;
        i_pwrite    = wr;
        i_apbPacket = '0;
        for (int c = 0; c < WINDOW; c++) begin
            @(posedge i_clk); #1;
            if (readyCount > 0) begin
                i_psel    = 1'b0;
                i_penable = 1'b0;
            end else begin
                i_penable = 1'b1;
            end
            if (rspAt > 0 && c == rspAt)          i_apbPacket = rspPkt;
            else if (wrongAt > 0 && c == wrongAt) i_apbPacket = wrongPkt;
            else                                  i_apbPacket = '0;
            #2;
            if (o_apbPacket !== '0) begin
                pktCount++;
                if (pktCycle < 0) begin
                    pktCycle = c;
                    pktSeen  = o_apbPacket;
                end
            end
            if (o_pready === 1'b1) begin
                readyCount++;
                if (readyCycle < 0) begin
                    readyCycle = c;
                    rdSeen     = o_prdata;
                    errSeen    = o_pslverr;
                end
            end else if (o_prdata !== '0 || o_pslverr !== 1'b0) begin
                stray++;
            end
            if (o_timeout === 1'b1) begin
                tmoCount++;
                if (tmoCycle < 0) tmoCycle = c;
            end
            if (o_dropped === 1'b1) begin
                dropCount++;
                if (dropCycle < 0) dropCycle = c;
            end
        end
        @(posedge i_clk); #1;
        i_psel      = 1'b0;
        i_penable   = 1'b0;
        i_apbPacket = '0;

        checks++;
        if (pktCount !== (isSelf ? 0 : 1)) begin
            errors++;
            $display("FAIL %s packet count: got %0d want %0d", name, pktCount, isSelf ? 0 : 1);
        end
        if (!isSelf) begin
            checks++;
            if (pktSeen !== expPkt || pktCycle !== 0) begin
                errors++;
                $display("FAIL %s request packet: got %h at cycle %0d want %h at cycle 0",
                         name, pktSeen, pktCycle, expPkt);
            end
        end
        checks++;
        if (readyCount !== 1 || readyCycle !== expReady) begin
            errors++;
            $display("FAIL %s pready: got %0d pulses first at %0d want 1 pulse at %0d",
                     name, readyCount, readyCycle, expReady);
        end
        checks++;
        if (rdSeen !== expRdata || errSeen !== expErr) begin
            errors++;
            $display("FAIL %s completion: got prdata %h pslverr %b want prdata %h pslverr %b",
                     name, rdSeen, errSeen, expRdata, expErr);
        end
        checks++;
        if (tmoCount !== expTmo || (expTmo == 1 && tmoCycle !== TMO + 1)) begin
            errors++;
            $display("FAIL %s timeout: got %0d pulses first at %0d want %0d at %0d",
                     name, tmoCount, tmoCycle, expTmo, TMO + 1);
        end
        checks++;
        if (dropCount !== expDrop || (wrongAt > 0 && dropCycle !== wrongAt + 1)) begin
            errors++;
            $display("FAIL %s dropped: got %0d pulses first at %0d want %0d at %0d",
                     name, dropCount, dropCycle, expDrop, wrongAt + 1);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL %s data without pready: got %0d cycles want 0", name, stray);
        end
    endtask

    task automatic test_reset;
        i_arst_n    = 1'b0;
        i_psel      = 1'b0;
        i_penable   = 1'b0;
        i_pwrite    = 1'b0;
        i_paddr     = '0;
        i_pwdata    = '0;
        i_apbPacket = mkPkt(1, 1, 0, 0, 1, 1, 0, 0, 0, 5);
        repeat (3) @(posedge i_clk);
        #3;
        checks++;
        if ({o_pready, o_pslverr, o_timeout, o_dropped} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: got %b want 0000", {o_pready, o_pslverr, o_timeout, o_dropped});
        end
        checks++;
        if (o_prdata !== '0 || o_apbPacket !== '0) begin
            errors++;
            $display("FAIL reset data: got prdata %h packet %h want 0", o_prdata, o_apbPacket);
        end
        i_apbPacket = '0;
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
        @(posedge i_clk); #3;
        checks++;
        if (o_dropped !== 1'b0 || o_apbPacket !== '0 || o_pready !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: got dropped %b packet %h pready %b want 0",
                     o_dropped, o_apbPacket, o_pready);
        end
    endtask

    task automatic test_write;
        runTxn("write_2010", 16'h2010, 32'hDEADBEEF, 1'b1, 5, $urandom, 1'b0, 0, 0);
    endtask

    task automatic test_read;
        runTxn("read_3004", 16'h3004, $urandom, 1'b0, 3, 32'h12345678, 1'b0, 0, 0);
    endtask

    task automatic test_timeout;
        runTxn("timeout", 16'h4000, $urandom, 1'b0, 0, 32'h0, 1'b0, 0, 0);
    endtask

    task automatic test_self;
        runTxn("self_access", 16'h5000, $urandom, 1'b0, 0, 32'h0, 1'b0, 0, 0);
    endtask

    task automatic test_wrong_src;
        runTxn("wrong_src", 16'h2010, $urandom, 1'b0, 4, 32'hCAFEF00D, 1'b0, 2, 3);
    endtask

    task automatic test_late_match;
        runTxn("match_at_timeout", 16'hC0F0, $urandom, 1'b0, TMO, 32'hA5A5_1234, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid_wait;
        int dropCount  = 0;
        int dropCycle  = -1;
        int readyCount = 0;
        int busy       = 0;
        @(posedge i_clk); #1;
        i_psel    = 1'b1;
        i_penable = 1'b0;
        i_paddr   = 16'hA123;
        i_pwdata  = $urandom;
        i_pwrite  = 1'b0;
        @(posedge i_clk); #1;
        i_penable = 1'b1;
        repeat (2) @(posedge i_clk);
        #3;
        i_arst_n = 1'b0;
        #1;
        checks++;
        if ({o_pready, o_pslverr, o_timeout, o_dropped} !== 4'b0000 || o_apbPacket !== '0) begin
            errors++;
            $display("FAIL reset in wait: got flags %b packet %h want all 0",
                     {o_pready, o_pslverr, o_timeout, o_dropped}, o_apbPacket);
        end
        i_psel    = 1'b0;
        i_penable = 1'b0;
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            i_apbPacket = (c == 1) ? mkPkt(1, 1, 2, 2, 1, 1, 0, 0, 16'hA123, 32'h55AA55AA) : '0;
            #2;
            if (o_dropped === 1'b1) begin
                dropCount++;
                if (dropCycle < 0) dropCycle = c;
            end
            if (o_pready !== 1'b0) readyCount++;
            if (o_apbPacket !== '0 || o_timeout !== 1'b0) busy++;
        end
        checks++;
        if (dropCount !== 1 || dropCycle !== 2) begin
            errors++;
            $display("FAIL stale response: got %0d drops first at %0d want 1 at 2", dropCount, dropCycle);
        end
        checks++;
        if (readyCount !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL after reset quiet: got pready %0d busy %0d want 0 0", readyCount, busy);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic [15:0] addr;
            logic        isSelf;
            int          rspAt;
            int          wrongAt;
            int          limit;
            addr    = 16'($urandom_range(0, 65535));
            isSelf  = (addr[15:14] == 2'd1) && (addr[13:12] == 2'd1);
            rspAt   = isSelf ? 0 : $urandom_range(0, TMO);
            wrongAt = 0;
            if (!isSelf && $urandom_range(0, 1) == 1) begin
                limit = (rspAt == 0) ? TMO : rspAt - 1;
                if (limit >= 1) wrongAt = $urandom_range(1, limit);
            end
            runTxn($sformatf("random_%0d", n), addr, $urandom, 1'($urandom_range(0, 1)),
                   rspAt, $urandom, 1'($urandom_range(0, 1)), wrongAt, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_self();
        test_wrong_src();
        test_late_match();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
